// File: rtl/tmul_row_sequencer.sv
// Row control stage for the tile-multiply FMA_Row datapath: walks k, fetches B rows,
// issues scalar/row/accumulator operands and captures the FMA product back into the accumulator.
module tmul_row_sequencer #(
  parameter int LANES   = 16,
  parameter int FMA_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4:0]           k_count,
  input  logic [LANES*16-1:0]  a_row,
  input  logic [LANES*16-1:0]  c_init,
  output logic                 busy,
  output logic                 done,
  output logic [LANES*16-1:0]  c_row,
  output logic                 b_rd_en,
  output logic [3:0]           b_rd_addr,
  input  logic [LANES*16-1:0]  b_rd_data,
  output logic [15:0]          fma_a,
  output logic [LANES*16-1:0]  fma_b,
  output logic [LANES*16-1:0]  fma_c,
  input  logic [LANES*16-1:0]  fma_prod
);

  localparam int RW = LANES * 16;
  localparam int WW = (FMA_LAT > 0) ? $clog2(FMA_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      k_q, k_d;
  logic [4:0]      kmax_q, kmax_d;
  logic [RW-1:0]   a_q, a_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [15:0]     fa_q, fa_d;
  logic [RW-1:0]   fb_q, fb_d;
  logic [RW-1:0]   fc_q, fc_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [4:0]      k_clamp;
  logic [4:0]      k_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      kmax_q  <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      fc_q    <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      kmax_q  <= kmax_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fc_q    <= fc_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign k_clamp = (k_count > 5'd16) ? 5'd16 : k_count;
  assign k_next  = k_q + 5'd1;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    kmax_d  = kmax_q;
    a_d     = a_q;
    acc_d   = acc_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fc_d    = fc_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_row;
          acc_d   = c_init;
          kmax_d  = k_clamp;
          k_d     = '0;
          state_d = (k_clamp == 5'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        fb_d    = b_rd_data;
        fa_d    = a_q[{k_q[3:0], 4'b0000} +: 16];
        fc_d    = acc_q;
        wcnt_d  = WW'(FMA_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Product is only trusted on the final WAIT cycle; earlier cycles may carry pipeline garbage.
        if (wcnt_q == '0) begin
          acc_d   = fma_prod;
          k_d     = k_next;
          state_d = (k_next < kmax_q) ? S_FETCH : S_DONE;
        end else begin
          wcnt_d = wcnt_q - WW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign b_rd_en   = (state_q == S_FETCH);
  assign b_rd_addr = k_q[3:0];
  assign c_row     = acc_q;
  assign fma_a     = fa_q;
  assign fma_b     = fb_q;
  assign fma_c     = fc_q;

endmodule
